// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply (shift-and-add) and divide (restoring)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d, rneg_q, rneg_d;
    logic                 dz_q, dz_d, busy_q, busy_d, done_q, done_d;
    logic                 sgn;
    logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
    logic [WIDTH:0]       msum, diff;
    logic [2*WIDTH-1:0]   mul_step, div_step, prod;

    // operand magnitudes, one multiply/divide iteration and the sign-corrected results
    always_comb begin
        sgn      = ~op[0];
        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & m_q};
        mul_step = {msum, acc_q[WIDTH-1:1]};
        diff     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        div_step = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // next-state and datapath update; the divisor (or multiplicand) sits in m, the working pair in acc
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (start) begin
                op_d   = op;
                cnt_d  = '0;
                neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d = sgn & a[WIDTH-1];
                if (op[1] && b == '0) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = CALC;
                    m_d     = op[1] ? mag_b : mag_a;
                    acc_d   = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                end
            end
            CALC: begin
                acc_d   = op_q[1] ? div_step : mul_step;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
                state_d      = DONE;
                dz_d         = 1'b0;
                {hi_d, lo_d} = op_q[1] ? {rem, quo} : prod;
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // all state and registered outputs; reset discards any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, busy, done, div_zero;
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // reference results computed with wide native arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[1]) begin
            p = o[0] ? {32'b0, x} * {32'b0, y} : 64'(sx * sy);
            e = '{hi: p[63:32], lo: p[31:0], dz: 1'b0};
        end else if (y == '0) begin
            e = '{hi: last_hi, lo: last_lo, dz: 1'b1};
        end else begin
            q = o[0] ? longint'({32'b0, x} / {32'b0, y}) : sx / sy;
            r = o[0] ? longint'({32'b0, x} % {32'b0, y}) : sx % sy;
            e = '{hi: r[31:0], lo: q[31:0], dz: 1'b0};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic push(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(o, x, y);
        sbq.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, "_sb"}, 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
        end
    endtask

    // called at a negedge: drives one op, scrambles inputs after the sampling edge, checks timing and result
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int lat, bc, exp_lat;
        push(o, x, y);
        exp_lat = (o[1] && y == '0) ? 1 : W + 2;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        lat = 0;
        bc = 0;
        do begin
            @(posedge clk);
            lat++;
            if (lat == 1) begin
                #1;
                start = 1'b0;
                op = ~o;
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            if (busy) bc++;
        end while (!done && lat < 200);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (done) compare_out(tag);
        while (busy && bc < 200) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check({tag, "_busy"}, 64'(bc), 64'(exp_lat));
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {61'b0, busy, done, div_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        run_op(2'b00, -32'sd3, 32'd7, "mult");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
        run_op(2'b11, 32'd100, 32'd7, "divu");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_min");
        run_op(2'b10, -32'sd7, 32'd2, "div_neg");
        run_op(2'b10, 32'd5, 32'd0, "div_zero");
        run_op(2'b00, 32'd6, -32'sd5, "mult_clr");
        // start pulses while busy and during the DONE cycle must be dropped
        push(2'b01, 32'd12, 32'd13);
        op = 2'b01;
        a = 32'd12;
        b = 32'd13;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        op = 2'b11;
        a = 32'd99;
        b = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ign_done", 64'(done), 64'd1);
        if (done) compare_out("ign");
        op = 2'b00;
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("ign_idle", 64'(busy), 64'd0);
        check("ign_hold", {hi, lo}, {last_hi, last_lo});
        // reset in the middle of a multiply
        op = 2'b00;
        a = 32'd123;
        b = -32'sd45;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ctl", {61'b0, busy, done, div_zero}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("mid_rst_quiet", 64'(n), 64'd0);
        run_op(2'b00, 32'd123, -32'sd45, "after_rst");
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 2) ? '0 : ((i == 4) ? 32'($urandom_range(1, 9)) : $urandom);
            run_op(ro, rx, ry, "rand");
        end
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
